// File: rtl/fir_sample_capture.sv
// Output-side capture buffer for the FIR filters. It discards the fill transient,
// stores DEPTH samples in RAM and drains them in order over a valid/ready read port.
module fir_sample_capture #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 400,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned SKIP   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              arm,
  output logic              busy,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned SKIP_W    = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
  localparam int unsigned SKIP_LAST = (SKIP > 0) ? SKIP - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_DRAIN} state_t;

  state_t            r_state;
  logic [SKIP_W-1:0] r_skip_cnt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_en;
  logic              w_hs;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_wr_en = (r_state == S_CAPTURE) && sample_valid;
  assign w_hs    = rd_valid && rd_ready;
  // Prefetch address keeps the drain at one sample per cycle through a registered read
  assign w_rd_addr = w_hs ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      busy       <= 1'b0;
      count      <= '0;
      overrun    <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      r_skip_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            count      <= '0;
            overrun    <= 1'b0;
            r_skip_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            busy       <= 1'b1;
            r_state    <= (SKIP > 0) ? S_SKIP : S_CAPTURE;
          end
        end
        S_SKIP: begin
          if (sample_valid) begin
            r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
            if (r_skip_cnt == SKIP_W'(SKIP_LAST)) begin
              r_state <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            count    <= count + CNT_W'(1);
            if (count == CNT_W'(DEPTH - 1)) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (sample_valid) begin
            overrun <= 1'b1;
          end
          if (w_hs && rd_last) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            // A stall re-reads the same address, so the presented sample holds
            rd_valid <= 1'b1;
            rd_data  <= r_mem[w_rd_addr];
            rd_last  <= (w_rd_addr == ADDR_W'(DEPTH - 1));
            r_rd_ptr <= w_rd_addr;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_capture.sv
// Bench for fir_sample_capture: a 400-deep/skip-16 instance and a 4-deep/skip-0
// instance, random stimulus, strobe-index reference model and scoreboard monitors.
module tb_fir_sample_capture;

  localparam int unsigned DW      = 8;
  localparam int unsigned A_DEPTH = 400;
  localparam int unsigned A_AW    = 9;
  localparam int unsigned A_SKIP  = 16;
  localparam int unsigned B_DEPTH = 4;
  localparam int unsigned B_AW    = 2;
  localparam int unsigned B_SKIP  = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic            a_arm = 1'b0, a_sv = 1'b0, a_rdy = 1'b0;
  logic [DW-1:0]   a_sin = '0;
  logic            a_busy, a_ovr, a_rvalid, a_rlast;
  logic [A_AW:0]   a_count;
  logic [DW-1:0]   a_rdata;

  logic            b_arm = 1'b0, b_sv = 1'b0, b_rdy = 1'b1;
  logic [DW-1:0]   b_sin = '0;
  logic            b_busy, b_ovr, b_rvalid, b_rlast;
  logic [B_AW:0]   b_count;
  logic [DW-1:0]   b_rdata;

  fir_sample_capture #(.DATA_W(DW), .DEPTH(A_DEPTH), .ADDR_W(A_AW), .SKIP(A_SKIP)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sample_in(a_sin), .sample_valid(a_sv), .arm(a_arm),
    .busy(a_busy), .count(a_count), .overrun(a_ovr), .rd_data(a_rdata),
    .rd_valid(a_rvalid), .rd_ready(a_rdy), .rd_last(a_rlast)
  );

  fir_sample_capture #(.DATA_W(DW), .DEPTH(B_DEPTH), .ADDR_W(B_AW), .SKIP(B_SKIP)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sample_in(b_sin), .sample_valid(b_sv), .arm(b_arm),
    .busy(b_busy), .count(b_count), .overrun(b_ovr), .rd_data(b_rdata),
    .rd_valid(b_rvalid), .rd_ready(b_rdy), .rd_last(b_rlast)
  );

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the n-th strobe after arm is kept iff SKIP <= n < SKIP+DEPTH
  exp_t qa[$];
  int   a_idx = 0;
  int   a_last_edge = 0;
  bit   a_exp_ovr = 1'b0;
  int   a_done = 0;
  int   a_rdy_mode = 0;
  int   a_hold = 0;

  exp_t qb[$];
  int   b_idx = 0;
  int   b_last_edge = 0;
  int   b_done = 0;

  task automatic a_strobe(input logic [DW-1:0] d);
    a_sv  = 1'b1;
    a_sin = d;
    if (a_idx >= int'(A_SKIP) && a_idx < int'(A_SKIP + A_DEPTH)) begin
      qa.push_back('{data: d, last: (a_idx == int'(A_SKIP + A_DEPTH) - 1)});
      if (a_idx == int'(A_SKIP + A_DEPTH) - 1) a_last_edge = cyc + 1;
    end else if (a_idx >= int'(A_SKIP + A_DEPTH)) begin
      a_exp_ovr = 1'b1;
    end
    a_idx++;
    tick();
    a_sv = 1'b0;
  endtask

  task automatic a_feed(input int n, input int gap_min, input int gap_max, input bit ramp);
    for (int i = 0; i < n; i++) begin
      a_strobe(ramp ? DW'(a_idx) : DW'($urandom));
      repeat (int'($urandom_range(gap_max, gap_min))) tick();
    end
  endtask

  task automatic a_arm_pulse();
    a_arm = 1'b1;
    tick();
    a_arm = 1'b0;
    a_idx = 0;
    a_exp_ovr = 1'b0;
    chk("a_arm_busy", a_busy, 1);
    chk("a_arm_count", a_count, 0);
    chk("a_arm_overrun", a_ovr, 0);
  endtask

  task automatic a_raw_arm();
    a_arm = 1'b1;
    tick();
    a_arm = 1'b0;
    chk("a_ignored_arm_busy", a_busy, 1);
  endtask

  task automatic a_wait_valid();
    int n = 0;
    while (!a_rvalid && n < 100) begin tick(); n++; end
    chk("a_wait_valid_timeout", a_rvalid, 1);
  endtask

  task automatic a_wait_done(input int prev);
    int n = 0;
    while (a_done == prev && n < 20000) begin tick(); n++; end
    chk("a_drain_done_timeout", a_done, prev + 1);
  endtask

  task automatic b_strobe(input logic [DW-1:0] d);
    b_sv  = 1'b1;
    b_sin = d;
    if (b_idx >= int'(B_SKIP) && b_idx < int'(B_SKIP + B_DEPTH)) begin
      qb.push_back('{data: d, last: (b_idx == int'(B_SKIP + B_DEPTH) - 1)});
      if (b_idx == int'(B_SKIP + B_DEPTH) - 1) b_last_edge = cyc + 1;
    end
    b_idx++;
    tick();
    b_sv = 1'b0;
  endtask

  task automatic b_arm_pulse();
    b_arm = 1'b1;
    tick();
    b_arm = 1'b0;
    b_idx = 0;
    chk("b_arm_busy", b_busy, 1);
    chk("b_arm_count", b_count, 0);
  endtask

  task automatic b_wait_done(input int prev);
    int n = 0;
    while (b_done == prev && n < 200) begin tick(); n++; end
    chk("b_drain_done_timeout", b_done, prev + 1);
  endtask

  // Ready driver for A: 0 = always ready, 1 = random with a 10-cycle stall on rd_last, 2 = stalled
  always @(posedge clk) begin
    #1;
    case (a_rdy_mode)
      0: a_rdy = 1'b1;
      1: begin
        if (a_rvalid && a_rlast && a_hold < 10) begin
          a_rdy = 1'b0;
          a_hold++;
        end else begin
          a_rdy = 1'($urandom_range(1, 0));
          if (!a_rvalid) a_hold = 0;
        end
      end
      default: a_rdy = 1'b0;
    endcase
  end

  logic          a_pv = 1'b0, a_pr = 1'b0, a_pl = 1'b0;
  logic [DW-1:0] a_pd = '0;
  bit            a_fall = 1'b0;
  int            a_fall_edge = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_pv   = 1'b0;
      a_fall = 1'b0;
    end else begin
      if (a_fall && cyc == a_fall_edge) begin
        a_fall = 1'b0;
        chk("a_after_last_valid", a_rvalid, 0);
        chk("a_after_last_busy", a_busy, 0);
        chk("a_count_held", a_count, A_DEPTH);
        chk("a_overrun", a_ovr, a_exp_ovr);
        a_done++;
      end
      if (a_rvalid) begin
        if (!a_pv) begin
          chk("a_first_valid_cycle", cyc, a_last_edge + 1);
          chk("a_count_full", a_count, A_DEPTH);
        end else if (!a_pr) begin
          chk("a_stall_data", a_rdata, a_pd);
          chk("a_stall_last", a_rlast, a_pl);
        end
        if (a_rdy) begin
          if (qa.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_transfer: got data %0d, want no transfer", $signed(a_rdata));
          end else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_rd_data", $signed(a_rdata), $signed(e.data));
            chk("a_rd_last", a_rlast, e.last);
            if (e.last) begin
              a_fall = 1'b1;
              a_fall_edge = cyc + 1;
            end
          end
        end
      end
      a_pv = a_rvalid;
      a_pr = a_rdy;
      a_pd = a_rdata;
      a_pl = a_rlast;
    end
  end

  logic b_pv = 1'b0;
  bit   b_fall = 1'b0;
  int   b_fall_edge = 0;
  int   b_prev_hs = 0;
  int   b_hs_n = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      b_pv   = 1'b0;
      b_fall = 1'b0;
      b_hs_n = 0;
    end else begin
      if (b_fall && cyc == b_fall_edge) begin
        b_fall = 1'b0;
        chk("b_after_last_valid", b_rvalid, 0);
        chk("b_after_last_busy", b_busy, 0);
        chk("b_count_held", b_count, B_DEPTH);
        b_done++;
      end
      if (b_rvalid) begin
        if (!b_pv) chk("b_first_valid_cycle", cyc, b_last_edge + 1);
        if (b_rdy) begin
          if (b_hs_n > 0) chk("b_back_to_back", cyc, b_prev_hs + 1);
          b_prev_hs = cyc;
          b_hs_n++;
          if (qb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_transfer: got data %0d, want no transfer", $signed(b_rdata));
          end else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_rd_data", $signed(b_rdata), $signed(e.data));
            chk("b_rd_last", b_rlast, e.last);
            if (e.last) begin
              b_fall = 1'b1;
              b_fall_edge = cyc + 1;
              b_hs_n = 0;
            end
          end
        end
      end
      b_pv = b_rvalid;
    end
  end

  initial begin
    int d;
    repeat (3) tick();
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_a_overrun", a_ovr, 0);
    chk("rst_a_rd_valid", a_rvalid, 0);
    chk("rst_a_rd_last", a_rlast, 0);
    chk("rst_a_rd_data", a_rdata, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_rd_valid", b_rvalid, 0);
    rst_n = 1'b1;
    tick();

    // Small instance: boundary values, then a random capture
    b_arm_pulse();
    b_strobe(8'hFF);
    b_strobe(8'h80);
    b_strobe(8'h7F);
    b_strobe(8'h00);
    b_wait_done(0);
    b_arm_pulse();
    for (int i = 0; i < 4; i++) begin
      b_strobe(DW'($urandom));
      repeat (int'($urandom_range(3, 0))) tick();
    end
    b_wait_done(1);

    // Reset in the middle of a capture
    a_rdy_mode = 0;
    a_arm_pulse();
    a_feed(int'(A_SKIP) + 57, 0, 2, 1'b0);
    chk("a_count_before_reset", a_count, 57);
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", a_busy, 0);
    chk("midrst_count", a_count, 0);
    chk("midrst_rd_valid", a_rvalid, 0);
    chk("midrst_overrun", a_ovr, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    qa.delete();
    a_idx = 0;
    tick();

    // Ramp, one strobe every 20 cycles, consumer always ready
    d = a_done;
    a_arm_pulse();
    a_feed(int'(A_SKIP + A_DEPTH), 19, 19, 1'b1);
    a_wait_done(d);

    // Random backpressure
    d = a_done;
    a_rdy_mode = 1;
    a_arm_pulse();
    a_feed(int'(A_SKIP + A_DEPTH), 0, 3, 1'b0);
    a_wait_done(d);

    // Strobes during a stalled drain
    d = a_done;
    a_rdy_mode = 0;
    a_arm_pulse();
    a_feed(int'(A_SKIP + A_DEPTH) - 1, 0, 2, 1'b0);
    a_rdy_mode = 2;
    a_feed(1, 0, 0, 1'b0);
    a_wait_valid();
    for (int i = 0; i < 3; i++) begin
      a_strobe(DW'($urandom));
      repeat (19) tick();
    end
    chk("a_overrun_in_drain", a_ovr, 1);
    a_rdy_mode = 1;
    a_wait_done(d);
    repeat (5) tick();
    chk("a_overrun_sticky_idle", a_ovr, 1);
    chk("a_count_idle", a_count, A_DEPTH);

    // Arm pulses in SKIP, CAPTURE and DRAIN are ignored
    d = a_done;
    a_rdy_mode = 2;
    a_arm_pulse();
    a_feed(5, 0, 2, 1'b0);
    a_raw_arm();
    chk("a_count_after_arm_in_skip", a_count, 0);
    a_feed(100, 0, 2, 1'b0);
    a_raw_arm();
    chk("a_count_after_arm_in_capture", a_count, 105 - int'(A_SKIP));
    a_feed(int'(A_SKIP + A_DEPTH) - 105, 0, 2, 1'b0);
    a_wait_valid();
    a_raw_arm();
    chk("a_count_after_arm_in_drain", a_count, A_DEPTH);
    a_rdy_mode = 0;
    a_wait_done(d);
    repeat (3) tick();
    chk("a_idle_after_arm_test", a_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog: got no end of test by cycle %0d, want completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir_sample_capture.md
# fir_sample_capture

Output-side capture buffer for the FIR filter blocks (`fir_filter`, `fir_filter_sep`). It takes the filter's signed output samples on a per-sample valid strobe and discards the first `SKIP` samples, which cover the filter fill transient. It then stores the next `DEPTH` samples in on-chip RAM and drains them through a valid/ready read port. This puts filter checking on the hardware side, in place of simulation-only file dumps.

## Interface
- `DATA_W`, 8: sample width, two's complement.
- `DEPTH`, 400: number of samples stored per capture; must be ≥ 2.
- `ADDR_W`, 9: RAM address width; must satisfy 2^ADDR_W ≥ DEPTH.
- `SKIP`, 16: samples discarded after `arm`; 0 is legal.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sample_in`  in  DATA_W  filter output sample, signed.
- `sample_valid`  in  1  one-cycle strobe; `sample_in` is valid in that cycle.
- `arm`  in  1  starts a capture; sampled only in IDLE.
- `busy`  out  1  high in SKIP, CAPTURE and DRAIN.
- `count`  out  ADDR_W+1  samples stored in the current capture.
- `overrun`  out  1  sticky; a sample arrived while the block was in DRAIN.
- `rd_data`  out  DATA_W  readout sample.
- `rd_valid`  out  1  `rd_data` is valid.
- `rd_ready`  in  1  consumer accepts `rd_data`.
- `rd_last`  out  1  qualifies the final sample (index DEPTH-1); meaningful only with `rd_valid`.

## Operation
- FSM states: IDLE, SKIP, CAPTURE, DRAIN.
- IDLE, `arm`=1:
  - clear `count`, `overrun`, the skip counter and the write pointer;
  - go to SKIP if SKIP>0, otherwise go to CAPTURE.
- `arm` outside IDLE is ignored.
- SKIP: each `sample_valid` increments the skip counter. The strobe that takes the counter to SKIP is still discarded; the FSM goes to CAPTURE on the next cycle.
- CAPTURE: each `sample_valid` writes `sample_in` to `mem[wr_ptr]` and increments `wr_ptr` and `count`. The write that takes `count` to DEPTH moves the FSM to DRAIN.
- DRAIN:
  - presents `mem[0]` .. `mem[DEPTH-1]` in order;
  - a sample transfers on `rd_valid && rd_ready`;
  - after the transfer with `rd_last`=1 the FSM returns to IDLE.
- `sample_valid` in DRAIN is dropped and sets `overrun`. `sample_valid` in IDLE is dropped and has no effect.
- Data is stored unmodified. There is no saturation or sign manipulation; the width is DATA_W end to end.
- `count` holds its final value (DEPTH) through DRAIN and IDLE until the next `arm`.
- RAM is a single array with a registered read port. It is not reset; contents are don't-care until written.

## Timing
- Reset (`rst_n`=0 at a rising edge) takes effect at that edge. Values after reset:
  - state IDLE;
  - `busy`=0, `count`=0, `overrun`=0;
  - `rd_valid`=0, `rd_last`=0, `rd_data`=0.
- Reset mid-operation, from any state, aborts immediately. Any partial capture is abandoned.
- `arm` at edge T → `busy`=1 from T+1.
- Final CAPTURE write at edge T:
  - `count`=DEPTH from T+1;
  - state DRAIN at T+1;
  - `rd_valid`=1 with `rd_data`=`mem[0]` from T+2.
- While `rd_valid`=1 and `rd_ready`=0, `rd_data`, `rd_valid` and `rd_last` hold stable.
- Handshake at edge N → the next sample is valid at N+1. With `rd_ready` held high the drain sustains one sample per cycle. This needs a registered read with a prefetch address: `rd_ptr+1` when handshaking, otherwise `rd_ptr`.
- Handshake with `rd_last`=1 at edge N → at N+1, `rd_valid`=0, `busy`=0 and state is IDLE. `arm` is accepted from N+1.
- `sample_valid` on the same edge as the final DRAIN handshake is dropped and does set `overrun`, because the state is still DRAIN.
- `sample_valid` on the same edge as `arm` in IDLE is not counted. Counting starts on the next cycle.

## Test plan
- **Reset:** drive `rst_n`=0 for 3 cycles mid-CAPTURE with `count`=57 → next cycle `busy`=0, `count`=0, `rd_valid`=0, `overrun`=0. A following `arm` restarts cleanly.
- **Basic capture:** DEPTH=400, SKIP=16; strobe every 20 cycles with a sample ramp 0,1,2,… → drained sequence is 16..415 wrapped to signed 8 bits, i.e. 16..127, then -128..127, then -128..-97. Exactly 400 transfers, `rd_last` only on the 400th. The first `rd_valid` arrives 2 cycles after the 416th strobe.
- **SKIP=0, DEPTH=4:** samples -1, -128, 127, 0 → read back -1, -128, 127, 0 with `rd_ready` tied high. This takes 4 consecutive cycles, and `busy` falls the cycle after the 4th handshake.
- **Backpressure:** toggle `rd_ready` pseudo-randomly, including holding it low for 10 cycles on `rd_last` → no sample is lost or duplicated, outputs are stable while stalled, and order is preserved.
- **Overrun:** continue strobing every 20 cycles during DRAIN with `rd_ready` low → `overrun`=1 and stays 1 through IDLE. The stored data is unchanged, and the next `arm` clears `overrun`.
- **Arm while busy:** pulse `arm` in SKIP, CAPTURE and DRAIN → no effect; `count` and the read sequence match the undisturbed run.
